ysyx_24080014_clint_axil: RTL and testbench

//  AXI4-lite responder (slave) implementing the core-local timer: 64-bit mtime, 64-bit mtimecmp, timer_irq.

---
 rtl/ysyx_24080014_axil_pkg.sv | 24 ++
 rtl/ysyx_24080014_mtime_cnt.sv | 53 +++++
 rtl/ysyx_24080014_clint_axil.sv | 163 ++++++++++++++++
 tb/tb_ysyx_24080014_clint_axil.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_axil_pkg.sv
// ysyx_24080014_axil_pkg: shared AXI4-lite response codes, CLINT register offsets, FSM state types
//   and a byte-strobe merge helper used by every writable register.
package ysyx_24080014_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] OFS_MTIME_LO    = 4'h0;
    localparam logic [3:0] OFS_MTIME_HI    = 4'h4;
    localparam logic [3:0] OFS_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] OFS_MTIMECMP_HI = 4'hC;

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ysyx_24080014_mtime_cnt.sv
// ysyx_24080014_mtime_cnt: prescaled 64-bit free-running timer with a byte-masked 32-bit load port.
//   aclk/aresetn : clock, asynchronous active-low reset
//   ld_en        : load this cycle (replaces the tick for this cycle)
//   ld_hi        : 1 selects mtime[63:32], 0 selects mtime[31:0]
//   ld_strb      : byte enables for ld_data
//   ld_data      : 32-bit load value
//   mtime        : current counter value
module ysyx_24080014_mtime_cnt
    import ysyx_24080014_axil_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ld_en,
    input  logic        ld_hi,
    input  logic [3:0]  ld_strb,
    input  logic [31:0] ld_data,
    output logic [63:0] mtime
);

    localparam int unsigned     PW      = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [63:0]   mtime_q, mtime_d;
    logic          tick;

    // A load wins over the tick; the prescaler keeps running so the tick phase is not disturbed.
    always_comb begin
        tick    = pre_q == PRE_MAX;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (ld_en) begin
            mtime_d = mtime_q;
            if (ld_hi) mtime_d[63:32] = strb_merge(mtime_q[63:32], ld_data, ld_strb);
            else       mtime_d[31:0]  = strb_merge(mtime_q[31:0], ld_data, ld_strb);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/ysyx_24080014_clint_axil.sv
// ysyx_24080014_clint_axil: AXI4-lite CLINT timer (mtime, mtimecmp, timer_irq) on a 16-byte window.
//   aclk/aresetn           : clock, asynchronous active-low reset
//   aw*/w*/b*              : AXI4-lite write address, data and response channels
//   ar*/r*                 : AXI4-lite read address and data channels
//   timer_irq              : registered unsigned (mtime >= mtimecmp)
module ysyx_24080014_clint_axil
    import ysyx_24080014_axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'ha0000048,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        timer_irq
);

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic [31:0] rdata_q, rdata_d, snap_q, snap_d;
    logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [63:0] mtimecmp_q, mtimecmp_d, mtime;
    logic        irq_q, irq_d;

    logic [31:0] r_off, w_off, w_addr, w_data;
    logic [3:0]  w_strb;
    logic        r_hit, w_hit, aw_fire, w_fire, do_wr, ld_en;

    // Offsets are taken relative to BASE_ADDR, which need not be 16-byte aligned.
    assign r_off = araddr - BASE_ADDR;
    assign r_hit = r_off[31:4] == '0 && r_off[1:0] == 2'b00;

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        snap_d    = snap_q;
        if (r_state_q == R_IDLE) begin
            if (arvalid) begin
                r_state_d = R_RESP;
                rresp_d   = r_hit ? RESP_OKAY : RESP_DECERR;
                rdata_d   = !r_hit                          ? '0 :
                            r_off[3:0] == OFS_MTIME_LO      ? mtime[31:0] :
                            r_off[3:0] == OFS_MTIME_HI      ? snap_q :
                            r_off[3:0] == OFS_MTIMECMP_LO   ? mtimecmp_q[31:0] : mtimecmp_q[63:32];
                // Reading the low half freezes the high half so a lo-then-hi pair is coherent.
                snap_d    = r_hit && r_off[3:0] == OFS_MTIME_LO ? mtime[63:32] : snap_q;
            end
        end else if (rready) begin
            r_state_d = R_IDLE;
        end
    end

    // AW and W latch independently; the write fires in the cycle both are available,
    // using the incoming beat directly when it arrives in that same cycle.
    assign aw_fire = awvalid && !aw_held_q;
    assign w_fire  = wvalid && !w_held_q;
    assign w_addr  = aw_held_q ? awaddr_q : awaddr;
    assign w_data  = w_held_q ? wdata_q : wdata;
    assign w_strb  = w_held_q ? wstrb_q : wstrb;
    assign w_off   = w_addr - BASE_ADDR;
    assign w_hit   = w_off[31:4] == '0 && w_off[1:0] == 2'b00;
    assign do_wr   = w_state_q == W_IDLE && (aw_held_q || aw_fire) && (w_held_q || w_fire);
    assign ld_en   = do_wr && w_hit && (w_off[3:0] == OFS_MTIME_LO || w_off[3:0] == OFS_MTIME_HI) && |w_strb;

    always_comb begin
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        aw_held_d  = aw_held_q || aw_fire;
        w_held_d   = w_held_q || w_fire;
        awaddr_d   = aw_fire ? awaddr : awaddr_q;
        wdata_d    = w_fire ? wdata : wdata_q;
        wstrb_d    = w_fire ? wstrb : wstrb_q;
        mtimecmp_d = mtimecmp_q;
        if (do_wr) begin
            w_state_d = W_RESP;
            bresp_d   = w_hit ? RESP_OKAY : RESP_DECERR;
            if (w_hit && w_off[3:0] == OFS_MTIMECMP_LO)
                mtimecmp_d[31:0] = strb_merge(mtimecmp_q[31:0], w_data, w_strb);
            if (w_hit && w_off[3:0] == OFS_MTIMECMP_HI)
                mtimecmp_d[63:32] = strb_merge(mtimecmp_q[63:32], w_data, w_strb);
        end
        if (w_state_q == W_RESP && bready) begin
            w_state_d = W_IDLE;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
    end

    assign irq_d = mtime >= mtimecmp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            snap_q     <= '0;
            w_state_q  <= W_IDLE;
            bresp_q    <= RESP_OKAY;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            snap_q     <= snap_d;
            w_state_q  <= w_state_d;
            bresp_q    <= bresp_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    ysyx_24080014_mtime_cnt #(.TICK_DIV(TICK_DIV)) u_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .ld_en   (ld_en),
        .ld_hi   (w_off[3:0] == OFS_MTIME_HI),
        .ld_strb (w_strb),
        .ld_data (w_data),
        .mtime   (mtime)
    );

    assign arready   = r_state_q == R_IDLE;
    assign rvalid    = r_state_q == R_RESP;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign awready   = !aw_held_q;
    assign wready    = !w_held_q;
    assign bvalid    = w_state_q == W_RESP;
    assign bresp     = bresp_q;
    assign timer_irq = irq_q;

endmodule

// File: tb/tb_ysyx_24080014_clint_axil.sv
// tb_ysyx_24080014_clint_axil: scoreboard bench for the AXI4-lite CLINT timer.
module tb_ysyx_24080014_clint_axil;

    localparam logic [31:0] BASE = 32'ha0000048;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic        awready, wready, bvalid, arready, rvalid, timer_irq;
    logic [1:0]  bresp, rresp;

    always #5 aclk = ~aclk;

    ysyx_24080014_clint_axil dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .timer_irq(timer_irq)
    );

    typedef struct { logic [31:0] lo; logic [31:0] hi; logic [1:0] resp; string name; } rexp_t;
    typedef struct { logic [1:0] resp; string name; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];

    int   n_chk = 0, n_fail = 0, cyc = 0, hs = 0, hs0 = 0;
    logic irq_at_b;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the oldest expectation whenever a response handshake is presented.
    rexp_t re;
    bexp_t be;
    always @(negedge aclk) begin
        if (aresetn && rvalid && rready) begin
            n_chk++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_r: rdata %0h rresp %0b with nothing expected", rdata, rresp);
            end else begin
                re = rq.pop_front();
                if (rresp !== re.resp || rdata < re.lo || rdata > re.hi) begin
                    n_fail++;
                    $display("FAIL %s: got rdata %0h rresp %0b expected rdata %0h..%0h rresp %0b",
                             re.name, rdata, rresp, re.lo, re.hi, re.resp);
                end
            end
        end
        if (aresetn && bvalid && bready) begin
            n_chk++;
            if (bq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_b: bresp %0b with nothing expected", bresp);
            end else begin
                be = bq.pop_front();
                if (bresp !== be.resp) begin
                    n_fail++;
                    $display("FAIL %s: got bresp %0b expected %0b", be.name, bresp, be.resp);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic rd(input logic [31:0] addr, input logic [31:0] lo, input logic [31:0] hi,
                      input logic [1:0] resp, input string name);
        int n = 0;
        rq.push_back('{lo: lo, hi: hi, resp: resp, name: name});
        araddr  = addr;
        arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && n < 20) begin n++; @(negedge aclk); end
        chk({name, "_arready"}, arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0;
        @(negedge aclk);
        chk({name, "_rlat"}, rvalid, 1);
        @(posedge aclk); #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] resp, input string name);
        int n = 0;
        bq.push_back('{resp: resp, name: name});
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge aclk);
        while (!(awready && wready) && n < 20) begin n++; @(negedge aclk); end
        chk({name, "_ready"}, awready && wready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        hs      = cyc;
        @(negedge aclk);
        chk({name, "_blat"}, bvalid, 1);
        irq_at_b = timer_irq;
        @(posedge aclk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_arready"}, arready, 1);
        chk({tag, "_awready"}, awready, 1);
        chk({tag, "_wready"}, wready, 1);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rresp"}, rresp, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_irq"}, timer_irq, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, then first read after exactly 10 counting cycles
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk_reset("t1_rst");
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (10) @(posedge aclk);
        #1;
        rd(BASE, 32'd10, 32'd10, 2'b00, "t1_rd_lo");

        // 2: carry into the high word and snapshot coherence
        wr(BASE, 32'hFFFF_FFF0, 4'hF, 2'b00, "t2_wr_lo");
        wr(BASE + 4, 32'h0, 4'hF, 2'b00, "t2_wr_hi");
        repeat (20) @(posedge aclk);
        #1;
        rd(BASE, 32'd6, 32'd6, 2'b00, "t2_rd_lo");
        wr(BASE + 4, 32'd5, 4'hF, 2'b00, "t2_wr_hi5");
        rd(BASE + 4, 32'd1, 32'd1, 2'b00, "t2_rd_snap");
        rd(BASE, 32'h0, 32'hFFFF_FFFF, 2'b00, "t2_rd_lo2");
        rd(BASE + 4, 32'd5, 32'd5, 2'b00, "t2_rd_snap2");

        // 3: AW three cycles ahead of W, B held off by bready
        bq.push_back('{resp: 2'b00, name: "t3_b"});
        awaddr  = BASE + 8;
        wdata   = 32'h1234_5678;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        @(negedge aclk);
        chk("t3_awready", awready, 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        @(negedge aclk);
        chk("t3_awready_drop", awready, 0);
        chk("t3_no_b_yet", bvalid, 0);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        bready = 1'b0;
        wvalid = 1'b1;
        @(negedge aclk);
        chk("t3_wready", wready, 1);
        @(posedge aclk); #1;
        wvalid  = 1'b0;
        awaddr  = BASE + 12;
        awvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t3_bvalid_hold", bvalid, 1);
            chk("t3_aw_blocked", awready, 0);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        bready  = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t3_awready_back", awready, 1);
        chk("t3_wready_back", wready, 1);
        @(posedge aclk); #1;

        // 4: byte strobes
        wr(BASE + 8, 32'h0000_0064, 4'b0001, 2'b00, "t4_wr_strb");
        rd(BASE + 8, 32'h1234_5664, 32'h1234_5664, 2'b00, "t4_rd_cmplo");
        wr(BASE + 12, 32'h0, 4'hF, 2'b00, "t4_wr_cmphi");
        wr(BASE + 12, 32'hFFFF_FFFF, 4'h0, 2'b00, "t4_wr_nostrb");
        rd(BASE + 12, 32'h0, 32'h0, 2'b00, "t4_rd_cmphi");

        // 5: interrupt edge timing
        wr(BASE + 12, 32'hFFFF_FFFF, 4'hF, 2'b00, "t5_cmphi_max");
        wr(BASE + 4, 32'h0, 4'hF, 2'b00, "t5_mt_hi0");
        wr(BASE, 32'h0, 4'hF, 2'b00, "t5_mt_lo0");
        hs0 = hs;
        wr(BASE + 8, 32'd100, 4'hF, 2'b00, "t5_cmplo");
        wr(BASE + 12, 32'h0, 4'hF, 2'b00, "t5_cmphi");
        @(negedge aclk);
        chk("t5_irq_low", timer_irq, 0);
        @(posedge aclk); #1;
        while (cyc < hs0 + 100) begin @(posedge aclk); #1; end
        @(negedge aclk);
        chk("t5_irq_not_yet", timer_irq, 0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t5_irq_rise", timer_irq, 1);
        @(posedge aclk); #1;
        wr(BASE + 8, 32'hFFFF_FFFF, 4'hF, 2'b00, "t5_cmplo_max");
        chk("t5_irq_at_b", irq_at_b, 1);
        chk("t5_irq_clear", timer_irq, 0);
        wr(BASE + 12, 32'hFFFF_FFFF, 4'hF, 2'b00, "t5_cmphi_max2");

        // 6: decode errors, then reset in the middle of a read
        rd(32'ha000_0058, 32'h0, 32'h0, 2'b11, "t6_rd_decerr");
        rd(32'ha000_0044, 32'h0, 32'h0, 2'b11, "t6_rd_below");
        wr(32'ha000_004A, 32'hDEAD_BEEF, 4'hF, 2'b11, "t6_wr_unaligned");
        rd(BASE + 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "t6_rd_cmplo");
        rd(BASE, 32'd100, 32'd1000, 2'b00, "t6_rd_mtlo");
        rd(BASE + 4, 32'h0, 32'h0, 2'b00, "t6_rd_mthi");
        rready  = 1'b0;
        araddr  = BASE + 8;
        arvalid = 1'b1;
        @(posedge aclk); #1 arvalid = 1'b0;
        @(negedge aclk);
        chk("t6_rvalid_before_rst", rvalid, 1);
        #2 aresetn = 1'b0;
        #1 chk_reset("t6_rst");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        rready  = 1'b1;
        rd(BASE + 12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "t6_rd_cmphi_rst");
        rd(BASE, 32'd0, 32'd5, 2'b00, "t6_rd_mtlo_rst");

        repeat (2) @(posedge aclk);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
